fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013: instruction driven on inst when not valid (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold PC and state this cycle.
REQ-006 branch  input  1  current instruction is a conditional branch (from decode).
REQ-007 is_jal  input  1  current instruction is jal.
REQ-008 is_jalr  input  1  current instruction is jalr.
REQ-009 br_cond  input  1  branch condition result from ALU.
REQ-010 imm  input  32  sign-extended immediate of current instruction.
REQ-011 jalr_target  input  32  rs1+imm computed by ALU.
REQ-012 is_halt  input  1  current instruction is ecall with x17==10.
REQ-013 imem_data  input  32  instruction word at imem_addr (combinational memory).
REQ-014 imem_addr  output  32  equals pc.
REQ-015 pc  output  32  current PC register.
REQ-016 pc_plus4  output  32  pc+4, for pc_to_reg writeback.
REQ-017 inst  output  32  instruction to decode: imem_data when inst_valid, else NOP_INST.
REQ-018 inst_valid  output  1  1 only in RUN state with stall=0.
REQ-019 halted  output  1  1 in HALTED state.
REQ-020 fault  output  1  1 in FAULT state.
REQ-021 retired  output  32  count of retired instructions.

Function
REQ-022 SHALL implement states BOOT, RUN, HALTED, FAULT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-023 In BOOT, HALTED, FAULT: pc, retired frozen; inst_valid=0; control inputs ignored.
REQ-024 In RUN with stall=1: pc, state, retired unchanged; inst_valid=0.
REQ-025 In RUN with stall=0, next_pc priority: is_jalr -> jalr_target & ~32'h1; else is_jal -> pc+imm; else branch&br_cond -> pc+imm; else pc+4.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32 (wrap, no overflow flag).
REQ-027 In RUN with stall=0 and is_halt=1: pc unchanged, retired increments, next state HALTED; is_halt overrides all branch/jump inputs.
REQ-028 In RUN with stall=0, is_halt=0 and next_pc[1:0]!=0: pc unchanged, retired unchanged, next state FAULT.
REQ-029 Otherwise in RUN with stall=0: pc<=next_pc, retired increments.
REQ-030 retired SHALL saturate at 32'hFFFF_FFFF.
REQ-031 HALTED and FAULT SHALL be exited only by reset.
REQ-032 pc_plus4 and imem_addr SHALL be combinational from pc, valid in every state.

Reset
REQ-033 reset_n=0 SHALL immediately (asynchronously) set pc=RESET_PC, retired=0, state=BOOT, halted=0, fault=0, inst_valid=0.
REQ-034 Reset asserted mid-operation in any state SHALL abort it with no partial update on the following edge.

Verification
REQ-035 Reset, release, 4 cycles no jumps -> cycle1 inst_valid=0, inst=32'h13; then pc 0,4,8; retired 0,1,2,3.
REQ-036 pc=0x10, branch=1, br_cond=1, imm=-8 -> pc=0x08; same with br_cond=0 -> pc=0x14.
REQ-037 pc=0x20, is_jalr=1, is_jal=1, jalr_target=0x101 -> pc=0x100 (jalr wins, bit0 cleared).
REQ-038 is_halt=1 with is_jal=1 -> halted=1, pc held, retired+1, inst_valid=0 thereafter until reset.
REQ-039 is_jal=1, imm=6 at pc=0 -> fault=1, pc stays 0, retired unchanged; stall=1 for 3 cycles in RUN -> pc and retired constant, inst=32'h13.
REQ-040 pc=32'hFFFF_FFFC, no jump -> pc=0 (wrap); reset_n pulsed low between edges -> outputs at reset values before next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage for a single-issue RV32 core: owns the PC, picks the
// next PC from jump/branch inputs, and sequences BOOT -> RUN -> HALTED/FAULT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        br_cond,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_target,
  input  logic        is_halt,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_retired;
  logic [31:0] w_retired_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_rel;
  logic [31:0] w_target;
  logic [31:0] w_retired_inc;
  logic        w_active;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_rel   = r_pc + imm;
  assign w_active   = (r_state == S_RUN) && !stall;

  // Priority: jalr, then jal, then taken branch, then sequential.
  always_comb begin
    if (is_jalr)                w_target = jalr_target & ~32'h1;
    else if (is_jal)            w_target = w_pc_rel;
    else if (branch && br_cond) w_target = w_pc_rel;
    else                        w_target = w_pc_plus4;
  end

  assign w_retired_inc = (r_retired == 32'hFFFF_FFFF) ? r_retired : r_retired + 32'd1;

  always_comb begin
    // NOTE: every output of this block is given a default first, so paths that
    // do not assign it keep the held value instead of inferring a latch.
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_retired_nxt = r_retired;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (is_halt) begin
            w_state_nxt   = S_HALTED;
            w_retired_nxt = w_retired_inc;
          end else if (w_target[1:0] != 2'b00) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_pc_nxt      = w_target;
            w_retired_nxt = w_retired_inc;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign pc         = r_pc;
  assign imem_addr  = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign inst_valid = w_active;
  assign inst       = w_active ? imem_data : NOP_INST;
  assign halted     = (r_state == S_HALTED);
  assign fault      = (r_state == S_FAULT);
  assign retired    = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational instruction
// memory whose word is a fixed function of its address.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch, is_jal, is_jalr, br_cond, is_halt;
  logic [31:0] imm, jalr_target, imem_data, imem_addr, pc, pc_plus4, inst, retired;
  logic        inst_valid, halted, fault;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ KEY;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch(branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .br_cond(br_cond), .imm(imm),
    .jalr_target(jalr_target), .is_halt(is_halt), .imem_data(imem_data),
    .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .inst(inst),
    .inst_valid(inst_valid), .halted(halted), .fault(fault), .retired(retired)
  );

  typedef struct {
    logic        st, br, bc, jal, jalr, halt;
    logic [31:0] imm, tgt;
    logic        ev;
    logic [31:0] epc, eret;
    logic        eh, ef;
  } vec_t;

  function automatic vec_t mk(logic st, logic br, logic bc, logic jal, logic jalr,
                              logic halt, logic [31:0] im, logic [31:0] tgt,
                              logic ev, logic [31:0] epc, logic [31:0] eret,
                              logic eh, logic ef);
    vec_t v;
    v.st = st; v.br = br; v.bc = bc; v.jal = jal; v.jalr = jalr; v.halt = halt;
    v.imm = im; v.tgt = tgt; v.ev = ev; v.epc = epc; v.eret = eret; v.eh = eh; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; branch = 0; is_jal = 0; is_jalr = 0; br_cond = 0; is_halt = 0;
    imm = 32'd0; jalr_target = 32'd0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t v, input string tag);
    stall = v.st; branch = v.br; br_cond = v.bc; is_jal = v.jal;
    is_jalr = v.jalr; is_halt = v.halt; imm = v.imm; jalr_target = v.tgt;
    #1;
    check({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, v.ev});
    check({tag, " inst"}, inst, v.ev ? (m_pc ^ KEY) : NOP);
    check({tag, " imem_addr"}, imem_addr, m_pc);
    check({tag, " pc_plus4"}, pc_plus4, m_pc + 32'd4);
    @(posedge clk); #1;
    check({tag, " pc"}, pc, v.epc);
    check({tag, " retired"}, retired, v.eret);
    check({tag, " halted"}, {31'd0, halted}, {31'd0, v.eh});
    check({tag, " fault"}, {31'd0, fault}, {31'd0, v.ef});
    m_pc = v.epc;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pc"}, pc, 32'd0);
    check({tag, " retired"}, retired, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " fault"}, {31'd0, fault}, 32'd0);
    check({tag, " inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, " inst"}, inst, NOP);
  endtask

  // Assert reset between edges, check it took effect immediately, hold it
  // across one rising edge and release on the following falling edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_pc = 32'd0;
  endtask

  vec_t tbl[19];
  vec_t idle_v;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    m_pc = 32'd0;

    //            st br bc jl jr ht imm           tgt           ev pc            ret     h  f
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'd0,  0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h4,        32'd1,  0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h8,        32'd2,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hC,        32'd3,  0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h10,       32'd4,  0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 32'hFFFFFFF8, 32'h0,        1, 32'h8,        32'd5,  0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 32'h8,        32'h0,        1, 32'h10,       32'd6,  0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 32'h0,        1, 32'h14,       32'd7,  0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 0, 0, 32'h64,       32'h0,        0, 32'h14,       32'd7,  0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 0, 0, 32'h64,       32'h0,        0, 32'h14,       32'd7,  0, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 32'h64,       32'h0,        0, 32'h14,       32'd7,  0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 32'hC,        32'h0,        1, 32'h20,       32'd8,  0, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 32'h4,        32'h101,      1, 32'h100,      32'd9,  0, 0);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 32'hFFFFFEFC, 32'h0,        1, 32'hFFFFFFFC, 32'd10, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        32'd11, 0, 0);
    tbl[15] = mk(0, 1, 1, 0, 0, 0, 32'h40,       32'h0,        1, 32'h40,       32'd12, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 1, 32'h8,        32'h0,        1, 32'h40,       32'd13, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h40,       32'd13, 1, 0);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 32'h4,        32'h0,        0, 32'h40,       32'd13, 1, 0);
    idle_v  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        32'd0,  0, 0);

    // Power-on reset, then the main table starting with the BOOT cycle.
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Misaligned jal target: fault, pc and retired frozen, controls ignored.
    do_reset("rst_halted");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'd0, 0, 0), "f_boot");
    step(mk(0, 0, 0, 1, 0, 0, 32'h6, 32'h0, 1, 32'h0, 32'd0, 0, 1), "f_jal6");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'd0, 0, 1), "f_hold");
    step(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 32'd0, 0, 1), "f_halt_ign");

    // Mid-run async reset aborts, then jalr landing on bit1 set faults.
    do_reset("rst_fault");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'd0, 0, 0), "r_boot");
    idle_v.epc = 32'h4; idle_v.eret = 32'd1;
    step(idle_v, "r_run1");
    idle_v.epc = 32'h8; idle_v.eret = 32'd2;
    step(idle_v, "r_run2");
    do_reset("rst_midrun");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'd0, 0, 0), "j_boot");
    step(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h7, 1, 32'h0, 32'd0, 0, 1), "j_jalr7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
